muldiv_sequencer: RTL and testbench

Sequences the shared multiply/divide resources (DIV, DIVU, MULT, MULTU units) and the HI/LO register file for the multicycle CPU. It accepts one HI/LO-class operation at a time from the main state machine, latches the operands, issues start/enable to the selected unit and waits for completion. It then drives HI/LO write enables and data, and signals done. It also produces the MFHI/MFLO hazard stall and handles divide-by-zero and a divider timeout.

---
 rtl/muldiv_sequencer_pkg.sv | 45 ++++
 rtl/muldiv_sequencer_if.sv | 31 +++
 rtl/muldiv_wait_counter.sv | 27 ++
 rtl/muldiv_sequencer.sv | 183 ++++++++++++++++++
 tb/tb_muldiv_sequencer.sv | 273 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/muldiv_sequencer_pkg.sv
// muldiv_sequencer_pkg: op/state encodings and helpers
// shared by the HI/LO multiply/divide sequencer.
package muldiv_sequencer_pkg;

  localparam logic [2:0] OP_DIV   = 3'd0;
  localparam logic [2:0] OP_DIVU  = 3'd1;
  localparam logic [2:0] OP_MULT  = 3'd2;
  localparam logic [2:0] OP_MULTU = 3'd3;
  localparam logic [2:0] OP_MTHI  = 3'd4;
  localparam logic [2:0] OP_MTLO  = 3'd5;

  localparam logic [2:0] S_IDLE     = 3'd0;
  localparam logic [2:0] S_START    = 3'd1;
  localparam logic [2:0] S_WAIT_DIV = 3'd2;
  localparam logic [2:0] S_WAIT_MUL = 3'd3;
  localparam logic [2:0] S_WRITE    = 3'd4;
  localparam logic [2:0] S_FINISH   = 3'd5;

  localparam int CNT_W = 6;

  typedef struct packed {
    logic [2:0]  op;
    logic [31:0] a;
    logic [31:0] b;
  } mdreq_t;

  function automatic logic is_div(
    input logic [2:0] op
  );
    return (op == OP_DIV) || (op == OP_DIVU);
  endfunction

  function automatic logic is_mt(
    input logic [2:0] op
  );
    return (op == OP_MTHI) || (op == OP_MTLO);
  endfunction

  function automatic logic is_legal(
    input logic [2:0] op
  );
    return op <= OP_MTLO;
  endfunction

endpackage

// File: rtl/muldiv_sequencer_if.sv
// muldiv_sequencer_if: CPU-side request/response bundle.
// master = main FSM/decode, slave = sequencer.
interface muldiv_sequencer_if;
  logic        req;
  logic [2:0]  op;
  logic [31:0] rs_data;
  logic [31:0] rt_data;
  logic        ack;
  logic        busy;
  logic        done;
  logic        div_zero;
  logic        err;
  logic        hilo_rd;
  logic        stall;
  logic        hi_en;
  logic        lo_en;
  logic [31:0] hi_wdata;
  logic [31:0] lo_wdata;

  modport master (
    output req, op, rs_data, rt_data, hilo_rd,
    input  ack, busy, done, div_zero, err, stall,
    input  hi_en, lo_en, hi_wdata, lo_wdata
  );

  modport slave (
    input  req, op, rs_data, rt_data, hilo_rd,
    output ack, busy, done, div_zero, err, stall,
    output hi_en, lo_en, hi_wdata, lo_wdata
  );
endinterface

// File: rtl/muldiv_wait_counter.sv
// muldiv_wait_counter: cycle counter with clear, enable
// and compare-to-limit (hit = cnt == limit).
module muldiv_wait_counter
  import muldiv_sequencer_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             en,
  input  logic [CNT_W-1:0] limit,
  output logic [CNT_W-1:0] cnt,
  output logic             hit
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (en) begin
      cnt <= cnt + CNT_W'(1);
    end
  end

  assign hit = (cnt == limit);

endmodule

// File: rtl/muldiv_sequencer.sv
// muldiv_sequencer: runs one HI/LO op at a time over the
// shared DIV/DIVU/MULT/MULTU units and writes HI/LO.
// Ports: clk, rst, cpu (slave), unit_a/b, div(u)_start,
// div(u)_busy/q/r, mul(tu)_ena, mul(tu)_z.
module muldiv_sequencer
  import muldiv_sequencer_pkg::*;
#(
  parameter int MUL_LAT     = 1,
  parameter int DIV_TIMEOUT = 40
) (
  input  logic        clk,
  input  logic        rst,
  muldiv_sequencer_if.slave cpu,
  output logic [31:0] unit_a,
  output logic [31:0] unit_b,
  output logic        div_start,
  output logic        divu_start,
  input  logic        div_busy,
  input  logic        divu_busy,
  input  logic [31:0] div_q,
  input  logic [31:0] div_r,
  input  logic [31:0] divu_q,
  input  logic [31:0] divu_r,
  output logic        mul_ena,
  output logic        multu_ena,
  input  logic [63:0] mul_z,
  input  logic [63:0] multu_z
);

  logic [2:0]       state;
  logic [2:0]       nxt;
  mdreq_t           req_q;
  logic             zero_q;
  logic             err_q;
  logic [31:0]      hi_res;
  logic [31:0]      lo_res;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] limit;
  logic             hit;
  logic             clr;
  logic             cnt_en;
  logic             accept;
  logic             sel_busy;
  logic [31:0]      sel_q;
  logic [31:0]      sel_r;
  logic [63:0]      sel_z;
  logic             div_ready;
  logic             div_tmo;
  logic             mul_cap;
  logic [2:0]       op_q;

  assign op_q   = req_q.op;
  assign unit_a = req_q.a;
  assign unit_b = req_q.b;
  assign accept = (state == S_IDLE) && cpu.req;

  assign sel_busy = (op_q == OP_DIVU) ? divu_busy : div_busy;
  assign sel_q    = (op_q == OP_DIVU) ? divu_q : div_q;
  assign sel_r    = (op_q == OP_DIVU) ? divu_r : div_r;
  assign sel_z    = (op_q == OP_MULTU) ? multu_z : mul_z;

  // Busy rises a cycle after start, so cnt==0 is ignored.
  assign div_ready = (state == S_WAIT_DIV)
                   && (cnt != '0) && !sel_busy;
  assign div_tmo   = (state == S_WAIT_DIV)
                   && !div_ready && hit;
  assign mul_cap   = (state == S_WAIT_MUL) && hit;

  assign limit = (state == S_WAIT_DIV)
               ? CNT_W'(DIV_TIMEOUT)
               : CNT_W'(MUL_LAT - 1);

  muldiv_wait_counter u_cnt (
    .clk   (clk),
    .rst   (rst),
    .clr   (clr),
    .en    (cnt_en),
    .limit (limit),
    .cnt   (cnt),
    .hit   (hit)
  );

  always_comb begin
    nxt    = state;
    clr    = 1'b0;
    cnt_en = 1'b0;
    unique case (state)
      S_IDLE: begin
        if (cpu.req) begin
          if (is_div(cpu.op) && cpu.rt_data == '0)
            nxt = S_FINISH;
          else if (is_mt(cpu.op))
            nxt = S_WRITE;
          else if (!is_legal(cpu.op))
            nxt = S_FINISH;
          else
            nxt = S_START;
        end
      end
      S_START: begin
        clr = 1'b1;
        nxt = is_div(op_q) ? S_WAIT_DIV : S_WAIT_MUL;
      end
      S_WAIT_DIV: begin
        cnt_en = 1'b1;
        if (div_ready)
          nxt = S_WRITE;
        else if (div_tmo)
          nxt = S_FINISH;
      end
      S_WAIT_MUL: begin
        cnt_en = 1'b1;
        if (mul_cap)
          nxt = S_WRITE;
      end
      S_WRITE:  nxt = S_IDLE;
      S_FINISH: nxt = S_IDLE;
      default:  nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= S_IDLE;
      req_q  <= '0;
      zero_q <= 1'b0;
      err_q  <= 1'b0;
      hi_res <= '0;
      lo_res <= '0;
    end else begin
      state <= nxt;
      if (accept) begin
        req_q  <= '{op: cpu.op,
                    a:  cpu.rs_data,
                    b:  cpu.rt_data};
        zero_q <= is_div(cpu.op)
               && (cpu.rt_data == '0);
        err_q  <= !is_legal(cpu.op);
      end
      if (div_ready) begin
        hi_res <= sel_r;
        lo_res <= sel_q;
      end else if (mul_cap) begin
        hi_res <= sel_z[63:32];
        lo_res <= sel_z[31:0];
      end
      if (div_tmo)
        err_q <= 1'b1;
    end
  end

  assign cpu.ack      = accept && !rst;
  assign cpu.busy     = (state != S_IDLE);
  assign cpu.done     = (state == S_WRITE)
                     || (state == S_FINISH);
  assign cpu.div_zero = (state == S_FINISH) && zero_q;
  assign cpu.err      = (state == S_FINISH) && err_q;
  assign cpu.stall    = cpu.hilo_rd && cpu.busy;

  assign cpu.hi_en = (state == S_WRITE)
                  && (op_q != OP_MTLO);
  assign cpu.lo_en = (state == S_WRITE)
                  && (op_q != OP_MTHI);

  assign cpu.hi_wdata = !cpu.hi_en ? '0
                      : (op_q == OP_MTHI) ? unit_a
                      : hi_res;
  assign cpu.lo_wdata = !cpu.lo_en ? '0
                      : (op_q == OP_MTLO) ? unit_a
                      : lo_res;

  assign div_start  = (state == S_START)
                   && (op_q == OP_DIV);
  assign divu_start = (state == S_START)
                   && (op_q == OP_DIVU);
  assign mul_ena    = ((state == S_START)
                   || (state == S_WAIT_MUL))
                   && (op_q == OP_MULT);
  assign multu_ena  = ((state == S_START)
                   || (state == S_WAIT_MUL))
                   && (op_q == OP_MULTU);

endmodule

// File: tb/tb_muldiv_sequencer.sv
// tb_muldiv_sequencer: directed bench with behavioural
// dividers/multipliers and a HI/LO register model.
module tb_muldiv_sequencer;
  import muldiv_sequencer_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] unit_a, unit_b;
  logic        div_start, divu_start;
  logic        div_busy, divu_busy;
  logic [31:0] dq, dr, duq, dur;
  logic        mul_ena, multu_ena;
  logic [63:0] mul_z, multu_z;
  logic        dbusy, dubusy, div_stuck;
  logic [5:0]  dcnt, ducnt;
  logic [31:0] hi_reg = '0;
  logic [31:0] lo_reg = '0;

  int passed = 0;
  int total  = 0;

  int          r_lat, r_starts, r_enas, r_bad;
  logic        r_ack, r_he, r_le, r_dz, r_er;
  logic [31:0] r_hw, r_lw;

  muldiv_sequencer_if cpu ();

  muldiv_sequencer dut (
    .clk        (clk),
    .rst        (rst),
    .cpu        (cpu),
    .unit_a     (unit_a),
    .unit_b     (unit_b),
    .div_start  (div_start),
    .divu_start (divu_start),
    .div_busy   (div_busy),
    .divu_busy  (divu_busy),
    .div_q      (dq),
    .div_r      (dr),
    .divu_q     (duq),
    .divu_r     (dur),
    .mul_ena    (mul_ena),
    .multu_ena  (multu_ena),
    .mul_z      (mul_z),
    .multu_z    (multu_z)
  );

  always #5 clk = ~clk;

  // 32-cycle behavioural dividers; busy rises after start.
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      dbusy <= 1'b0; dcnt <= '0; dq <= '0; dr <= '0;
    end else if (div_start) begin
      dbusy <= 1'b1; dcnt <= 6'd31;
      if (unit_b != '0) begin
        dq <= 32'($signed(unit_a) / $signed(unit_b));
        dr <= 32'($signed(unit_a) % $signed(unit_b));
      end
    end else if (dbusy) begin
      if (dcnt == '0) dbusy <= 1'b0;
      else dcnt <= dcnt - 6'd1;
    end
  end

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      dubusy <= 1'b0; ducnt <= '0; duq <= '0; dur <= '0;
    end else if (divu_start) begin
      dubusy <= 1'b1; ducnt <= 6'd31;
      if (unit_b != '0) begin
        duq <= unit_a / unit_b;
        dur <= unit_a % unit_b;
      end
    end else if (dubusy) begin
      if (ducnt == '0) dubusy <= 1'b0;
      else ducnt <= ducnt - 6'd1;
    end
  end

  assign div_busy  = dbusy | div_stuck;
  assign divu_busy = dubusy;
  assign mul_z   = $signed({{32{unit_a[31]}}, unit_a})
                 * $signed({{32{unit_b[31]}}, unit_b});
  assign multu_z = {32'b0, unit_a} * {32'b0, unit_b};

  always @(posedge clk) begin
    if (cpu.hi_en) hi_reg <= cpu.hi_wdata;
    if (cpu.lo_en) lo_reg <= cpu.lo_wdata;
  end

  task automatic chk(input string tag,
                     input logic [63:0] obs,
                     input logic [63:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0h expected %0h",
                tag, obs, exp);
  endtask

  // Issues one request in the next cycle and follows it
  // until done (bounded); collects results in r_*.
  task automatic run_op(input logic [2:0]  o,
                        input logic [31:0] a,
                        input logic [31:0] b,
                        input logic        rd);
    @(negedge clk);
    r_lat = 0; r_starts = 0; r_enas = 0; r_bad = 0;
    r_he = 0; r_le = 0; r_dz = 0; r_er = 0;
    r_hw = '0; r_lw = '0;
    if (cpu.busy !== 1'b0 || cpu.done !== 1'b0 ||
        cpu.stall !== 1'b0) r_bad++;
    cpu.req = 1'b1; cpu.op = o;
    cpu.rs_data = a; cpu.rt_data = b; cpu.hilo_rd = rd;
    #1 r_ack = cpu.ack;
    @(posedge clk); #1;
    cpu.req = 1'b0; cpu.op = 3'd7;
    cpu.rs_data = 32'hDEADBEEF; cpu.rt_data = '0;
    for (int k = 1; k <= 100; k++) begin
      @(negedge clk);
      if (div_start | divu_start) r_starts++;
      if (mul_ena | multu_ena) r_enas++;
      if (cpu.busy !== 1'b1 || cpu.stall !== rd) r_bad++;
      if (unit_a !== a || unit_b !== b) r_bad++;
      if (!cpu.hi_en && cpu.hi_wdata !== '0) r_bad++;
      if (!cpu.lo_en && cpu.lo_wdata !== '0) r_bad++;
      if (cpu.done === 1'b1) begin
        r_lat = k;
        r_he = cpu.hi_en; r_le = cpu.lo_en;
        r_hw = cpu.hi_wdata; r_lw = cpu.lo_wdata;
        r_dz = cpu.div_zero; r_er = cpu.err;
        break;
      end
      if (cpu.hi_en | cpu.lo_en | cpu.div_zero | cpu.err)
        r_bad++;
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    rst = 1'b1; div_stuck = 1'b0;
    cpu.req = 1'b1; cpu.op = OP_DIV;
    cpu.rs_data = 32'h11; cpu.rt_data = 32'h22;
    cpu.hilo_rd = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_ack", 64'(cpu.ack), 64'(0));
    chk("rst_busy_stall",
        64'({cpu.busy, cpu.stall, cpu.done}), 64'(0));
    chk("rst_hilo_en",
        64'({cpu.hi_en, cpu.lo_en}), 64'(0));
    chk("rst_units", {unit_a, unit_b}, 64'(0));
    cpu.req = 1'b0; cpu.hilo_rd = 1'b0;
    @(negedge clk) rst = 1'b0;

    // DIV -7 / 2
    run_op(OP_DIV, 32'hFFFFFFF9, 32'd2, 1'b0);
    chk("div_ack", 64'(r_ack), 64'(1));
    chk("div_lat", 64'(r_lat), 64'(35));
    chk("div_hi", 64'(r_hw), 64'h0000_0000_FFFF_FFFF);
    chk("div_lo", 64'(r_lw), 64'h0000_0000_FFFF_FFFD);
    chk("div_en", 64'({r_he, r_le, r_dz, r_er}),
        64'(4'b1100));
    chk("div_starts", 64'(r_starts), 64'(1));
    chk("div_bad", 64'(r_bad), 64'(0));

    // MULTU 0xFFFFFFFF * 2
    run_op(OP_MULTU, 32'hFFFFFFFF, 32'd2, 1'b0);
    chk("multu_lat", 64'(r_lat), 64'(3));
    chk("multu_hi", 64'(r_hw), 64'h1);
    chk("multu_lo", 64'(r_lw), 64'hFFFF_FFFE);
    chk("multu_ena_cycles", 64'(r_enas), 64'(2));
    chk("multu_bad", 64'(r_bad), 64'(0));
    chk("hifile_after_div", 64'(hi_reg), 64'hFFFF_FFFF);

    // DIVU by zero
    run_op(OP_DIVU, 32'd55, 32'd0, 1'b0);
    chk("dz_lat", 64'(r_lat), 64'(1));
    chk("dz_flags", 64'({r_he, r_le, r_dz, r_er}),
        64'(4'b0010));
    chk("dz_starts", 64'(r_starts), 64'(0));
    chk("dz_bad", 64'(r_bad), 64'(0));

    // MTLO with hilo_rd held high
    run_op(OP_MTLO, 32'h12345678, 32'h0, 1'b1);
    chk("mtlo_lat", 64'(r_lat), 64'(1));
    chk("mtlo_en", 64'({r_he, r_le}), 64'(2'b01));
    chk("mtlo_data", 64'({r_hw, r_lw}),
        64'h0000_0000_1234_5678);
    chk("mtlo_stall_bad", 64'(r_bad), 64'(0));
    chk("hilo_kept_dz", {hi_reg, lo_reg},
        64'h0000_0001_FFFF_FFFE);

    // MTHI
    run_op(OP_MTHI, 32'hCAFEF00D, 32'h5, 1'b0);
    chk("mthi_en", 64'({r_he, r_le}), 64'(2'b10));
    chk("mthi_data", 64'({r_hw, r_lw}),
        64'hCAFE_F00D_0000_0000);
    chk("lofile_mtlo", 64'(lo_reg), 64'h1234_5678);

    // Illegal op
    run_op(3'd6, 32'h1, 32'h2, 1'b0);
    chk("ill_lat", 64'(r_lat), 64'(1));
    chk("ill_flags", 64'({r_he, r_le, r_dz, r_er}),
        64'(4'b0001));
    chk("ill_bad", 64'(r_bad), 64'(0));

    // Divider busy stuck high: timeout
    div_stuck = 1'b1;
    run_op(OP_DIV, 32'd100, 32'd3, 1'b0);
    div_stuck = 1'b0;
    chk("tmo_lat", 64'(r_lat), 64'(43));
    chk("tmo_flags", 64'({r_he, r_le, r_dz, r_er}),
        64'(4'b0001));
    chk("tmo_bad", 64'(r_bad), 64'(0));

    // MULT right after the timeout done
    run_op(OP_MULT, 32'hFFFFFFFD, 32'd5, 1'b0);
    chk("b2b_ack", 64'(r_ack), 64'(1));
    chk("mult_lat", 64'(r_lat), 64'(3));
    chk("mult_z", 64'({r_hw, r_lw}),
        64'hFFFF_FFFF_FFFF_FFF1);
    chk("mult_ena_cycles", 64'(r_enas), 64'(2));
    chk("hifile_after_tmo", 64'(hi_reg), 64'hCAFE_F00D);

    // Reset in the middle of WAIT_DIV
    @(negedge clk);
    cpu.req = 1'b1; cpu.op = OP_DIVU;
    cpu.rs_data = 32'd100; cpu.rt_data = 32'd7;
    cpu.hilo_rd = 1'b1;
    @(posedge clk); #1 cpu.req = 1'b0;
    repeat (5) @(negedge clk);
    chk("pre_rst_stall", 64'({cpu.busy, cpu.stall}),
        64'(2'b11));
    rst = 1'b1;
    #1;
    chk("midrst_outs",
        64'({cpu.busy, cpu.done, cpu.ack, cpu.stall,
             cpu.hi_en, cpu.lo_en, cpu.err, cpu.div_zero,
             div_start, divu_start, mul_ena, multu_ena}),
        64'(0));
    chk("midrst_units", {unit_a, unit_b}, 64'(0));
    chk("midrst_wdata",
        {cpu.hi_wdata, cpu.lo_wdata}, 64'(0));
    repeat (2) @(posedge clk);
    @(negedge clk) rst = 1'b0;
    cpu.hilo_rd = 1'b0;
    repeat (3) @(negedge clk);
    chk("midrst_hilo_kept", {hi_reg, lo_reg},
        64'hFFFF_FFFF_FFFF_FFF1);
    chk("midrst_idle", 64'(cpu.busy), 64'(0));

    // Fresh DIVU after reset
    run_op(OP_DIVU, 32'd100, 32'd7, 1'b0);
    chk("post_ack", 64'(r_ack), 64'(1));
    chk("post_lat", 64'(r_lat), 64'(35));
    chk("post_divu", 64'({r_hw, r_lw}),
        64'h0000_0002_0000_000E);
    chk("post_bad", 64'(r_bad), 64'(0));

    @(negedge clk);
    chk("final_idle", 64'({cpu.busy, cpu.done}), 64'(0));

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
